edge_event_arbiter: RTL and testbench

- Collects rising-edge events from N_CH independent level inputs, such as synchronized buttons or status lines.
- Each channel has a Moore edge detector that produces a one-cycle tick. Ticks latch into per-channel pending flags.
- A round-robin scheduler offers pending events one at a time to a single downstream consumer over a valid/ready handshake.
- Sits between input conditioning and the control FSM that consumes discrete events.

---
 rtl/edge_arb_pkg.sv | 53 +++++
 rtl/edge_event_arbiter_cell.sv | 43 ++++
 rtl/edge_event_arbiter.sv | 122 ++++++++++++
 tb/tb_edge_event_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/edge_arb_pkg.sv
// Shared types and helpers for the edge event arbiter.
// Holds the state encodings of the edge cell and the scheduler, plus the
// round-robin search used to pick the next pending channel.
package edge_arb_pkg;

  // Per-channel rising-edge detector states.
  typedef enum logic [1:0] {
    CELL_ZERO = 2'b00,
    CELL_EDGE = 2'b01,
    CELL_ONE  = 2'b10
  } cell_state_t;

  // Scheduler states: nothing offered, or one event offered downstream.
  typedef enum logic {
    SCH_IDLE  = 1'b0,
    SCH_OFFER = 1'b1
  } sched_state_t;

  // Largest channel count the helpers below are sized for.
  localparam int MAX_CH    = 16;
  localparam int MAX_IDX_W = 4;

  // Round-robin search. Looks for the first set bit of req starting at ptr
  // and wrapping at n. Result is {found, index}; index is 0 when nothing is
  // found. Only the low n bits of req are considered.
  function automatic logic [MAX_IDX_W:0] rr_pick(
    input logic [MAX_CH-1:0]    req,
    input logic [MAX_IDX_W-1:0] ptr,
    input int                   n
  );
    logic [MAX_IDX_W:0] res;
    int                 idx;
    res = '0;
    for (int k = 0; k < MAX_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && !res[MAX_IDX_W] && req[idx[MAX_IDX_W-1:0]]) begin
        res = {1'b1, idx[MAX_IDX_W-1:0]};
      end
    end
    return res;
  endfunction

  // Index following idx, wrapping to 0 after n-1.
  function automatic logic [MAX_IDX_W-1:0] rr_inc(
    input logic [MAX_IDX_W-1:0] idx,
    input int                   n
  );
    if (int'(idx) + 1 >= n) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/edge_event_arbiter_cell.sv
// One channel's Moore rising-edge detector.
// tick is high for exactly the one cycle spent in CELL_EDGE, so a level that
// is already high when reset releases still yields a single tick.
module edge_tick_cell
  import edge_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic tick
);

  cell_state_t state;
  cell_state_t state_next;

  // State register with synchronous reset to CELL_ZERO.
  always_ff @(posedge clk) begin
    if (reset) state <= CELL_ZERO;
    else       state <= state_next;
  end

  // Next-state logic and Moore tick output.
  always_comb begin
    state_next = state;
    tick       = 1'b0;
    case (state)
      CELL_ZERO: begin
        if (level) state_next = CELL_EDGE;
      end
      CELL_EDGE: begin
        tick       = 1'b1;
        state_next = level ? CELL_ONE : CELL_ZERO;
      end
      CELL_ONE: begin
        if (!level) state_next = CELL_ZERO;
      end
      default: begin
        state_next = CELL_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge event arbiter: captures rising edges of N_CH level inputs into pending
// flags and hands them one at a time to a consumer in round-robin order.
//
// Handshake: ev_valid/ev_ch form a registered offer. Once ev_valid is high,
// ev_ch stays stable until the cycle in which ev_ready is also high; that
// clock edge is the transfer. ev_ready is ignored while ev_valid is low.
// After a transfer the next pending channel (if any) is offered on the very
// next cycle without ev_valid dropping.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int IDX_W = 2
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  level,
  input  logic             en,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [IDX_W-1:0] ev_ch,
  output logic [N_CH-1:0]  ev_pending,
  output logic [N_CH-1:0]  overflow,
  input  logic             clr_overflow
);

  if ((N_CH < 2) || (N_CH > MAX_CH) || (IDX_W != $clog2(N_CH))) begin : g_param_check
    $error("edge_event_arbiter: N_CH must be 2..16 and IDX_W must equal clog2(N_CH)");
  end

  logic [N_CH-1:0]    tick;
  logic [N_CH-1:0]    capture;
  logic [N_CH-1:0]    acc_vec;
  logic [N_CH-1:0]    remaining;
  logic               accept;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   ptr_next;
  logic [IDX_W-1:0]   ev_ch_next;
  logic [MAX_IDX_W:0] pick_idle;
  logic [MAX_IDX_W:0] pick_after;
  sched_state_t       sched_state;
  sched_state_t       sched_state_next;

  // One edge detector per channel.
  for (genvar i = 0; i < N_CH; i++) begin : g_cell
    edge_tick_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .level (level[i]),
      .tick  (tick[i])
    );
  end

  assign ev_valid = (sched_state == SCH_OFFER);
  assign accept   = ev_valid && ev_ready;

  // Ticks recorded this edge, and the one-hot of the channel being accepted.
  always_comb begin
    capture = en ? tick : '0;
    acc_vec = '0;
    if (accept) acc_vec[ev_ch] = 1'b1;
    remaining = ev_pending & ~acc_vec;
  end

  // Pending and sticky overflow flags; a new tick beats an accept or a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ev_pending <= '0;
      overflow   <= '0;
    end else begin
      ev_pending <= remaining | capture;
      if (clr_overflow) overflow <= capture & remaining;
      else              overflow <= overflow | (capture & remaining);
    end
  end

  // Scheduler registers: state, offered channel and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      sched_state <= SCH_IDLE;
      ev_ch       <= '0;
      ptr         <= '0;
    end else begin
      sched_state <= sched_state_next;
      ev_ch       <= ev_ch_next;
      ptr         <= ptr_next;
    end
  end

  // Scheduler next-state: pick from ptr when idle, re-pick after each accept.
  always_comb begin
    sched_state_next = sched_state;
    ev_ch_next       = ev_ch;
    ptr_next         = ptr;
    pick_idle        = rr_pick(MAX_CH'(ev_pending), MAX_IDX_W'(ptr), N_CH);
    pick_after       = rr_pick(MAX_CH'(remaining),
                               rr_inc(MAX_IDX_W'(ev_ch), N_CH), N_CH);
    case (sched_state)
      SCH_IDLE: begin
        if (pick_idle[MAX_IDX_W]) begin
          ev_ch_next       = IDX_W'(pick_idle[MAX_IDX_W-1:0]);
          sched_state_next = SCH_OFFER;
        end
      end
      SCH_OFFER: begin
        if (ev_ready) begin
          ptr_next = IDX_W'(rr_inc(MAX_IDX_W'(ev_ch), N_CH));
          if (pick_after[MAX_IDX_W]) begin
            ev_ch_next = IDX_W'(pick_after[MAX_IDX_W-1:0]);
          end else begin
            sched_state_next = SCH_IDLE;
          end
        end
      end
      default: begin
        sched_state_next = SCH_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios followed by random
// traffic, every cycle compared with a behavioural model of the event rules.
module tb_edge_event_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] level;
  logic         en;
  logic         ev_valid;
  logic         ev_ready;
  logic [W-1:0] ev_ch;
  logic [N-1:0] ev_pending;
  logic [N-1:0] overflow;
  logic         clr_overflow;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Model state
  logic [N-1:0] m_prev, m_tick, m_pend, m_ovf;
  logic         m_valid;
  int           m_ch, m_ptr;
  logic [W-1:0] exp_q[$];

  edge_event_arbiter #(.N_CH(N), .IDX_W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .level        (level),
    .en           (en),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_ch        (ev_ch),
    .ev_pending   (ev_pending),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  function automatic int pick(input logic [N-1:0] pend, input int from);
    for (int k = 0; k < N; k++) begin
      if (pend[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge using the inputs held before it.
  task automatic model_edge();
    logic [N-1:0] abit, cap, rem;
    logic         acc;
    int           p;
    if (reset) begin
      m_prev = '0; m_tick = '0; m_pend = '0; m_ovf = '0;
      m_valid = 1'b0; m_ch = 0; m_ptr = 0;
    end else begin
      acc  = m_valid && ev_ready;
      abit = acc ? N'(1 << m_ch) : '0;
      cap  = en ? m_tick : '0;
      rem  = m_pend & ~abit;
      m_ovf = clr_overflow ? (cap & rem) : (m_ovf | (cap & rem));
      if (acc) exp_q.push_back(W'(m_ch));
      if (!m_valid) begin
        p = pick(m_pend, m_ptr);
        if (p >= 0) begin m_valid = 1'b1; m_ch = p; end
      end else if (acc) begin
        m_ptr = (m_ch + 1) % N;
        p = pick(rem, m_ptr);
        if (p >= 0) m_ch = p;
        else        m_valid = 1'b0;
      end
      m_pend = rem | cap;
      m_tick = level & ~m_prev;
      m_prev = level;
    end
  endtask

  // One clock: note any offered transfer, step the model, compare after edge.
  task automatic cycle();
    logic         dut_acc;
    logic [W-1:0] dut_ch;
    dut_acc = ev_valid && ev_ready && !reset;
    dut_ch  = ev_ch;
    @(posedge clk);
    model_edge();
    #1;
    check("ev_valid", 32'(ev_valid), 32'(m_valid));
    check("ev_ch", 32'(ev_ch), 32'(m_ch));
    check("ev_pending", 32'(ev_pending), 32'(m_pend));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (dut_acc) begin
      if (exp_q.size() == 0) check("accept_unexpected", 32'(1), 32'(0));
      else                   check("accept_ch", 32'(dut_ch), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    reset = 1'b1; level = '0; en = 1'b1; ev_ready = 1'b0; clr_overflow = 1'b0;
    m_prev = '0; m_tick = '0; m_pend = '0; m_ovf = '0;
    m_valid = 1'b0; m_ch = 0; m_ptr = 0;
    repeat (2) cycle();
    check("rst_valid", 32'(ev_valid), 32'(0));
    check("rst_pend", 32'(ev_pending), 32'(0));
    check("rst_ovf", 32'(overflow), 32'(0));
    check("rst_ch", 32'(ev_ch), 32'(0));
    reset = 1'b0;

    // single pulse on ch2
    ev_ready = 1'b1; level = 4'b0100;
    cycle(); cycle();
    check("pulse_pend", 32'(ev_pending), 32'(4'b0100));
    check("pulse_wait", 32'(ev_valid), 32'(0));
    cycle();
    check("pulse_valid", 32'(ev_valid), 32'(1));
    check("pulse_ch", 32'(ev_ch), 32'(2));
    cycle();
    check("pulse_drop", 32'(ev_valid), 32'(0));
    repeat (4) cycle();
    check("pulse_held", 32'(ev_valid), 32'(0));
    level = '0; repeat (2) cycle();

    // simultaneous ch0, ch1, ch3 from ptr 0
    reset = 1'b1; cycle(); reset = 1'b0;
    level = 4'b1011; cycle(); cycle();
    cycle(); check("sim_first", 32'(ev_ch), 32'(0)); check("sim_v0", 32'(ev_valid), 32'(1));
    cycle(); check("sim_second", 32'(ev_ch), 32'(1)); check("sim_v1", 32'(ev_valid), 32'(1));
    cycle(); check("sim_third", 32'(ev_ch), 32'(3)); check("sim_v3", 32'(ev_valid), 32'(1));
    cycle(); check("sim_done", 32'(ev_valid), 32'(0));
    level = '0; repeat (2) cycle();

    // backpressure with ch1 offered while ch0 rises
    ev_ready = 1'b0; level = 4'b0010; repeat (3) cycle();
    check("bp_offer", 32'(ev_ch), 32'(1));
    level = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_hold_ch", 32'(ev_ch), 32'(1));
      check("bp_hold_valid", 32'(ev_valid), 32'(1));
    end
    ev_ready = 1'b1; cycle();
    check("bp_next_ch", 32'(ev_ch), 32'(0));
    check("bp_next_valid", 32'(ev_valid), 32'(1));
    cycle(); check("bp_done", 32'(ev_valid), 32'(0));
    level = '0; repeat (2) cycle();

    // overflow on ch3
    ev_ready = 1'b0;
    level = 4'b1000; cycle(); level = '0; cycle(); cycle();
    level = 4'b1000; cycle(); level = '0; cycle(); cycle();
    check("ovf_set", 32'(overflow), 32'(4'b1000));
    check("ovf_pend", 32'(ev_pending), 32'(4'b1000));
    clr_overflow = 1'b1; cycle(); clr_overflow = 1'b0;
    check("ovf_clr", 32'(overflow), 32'(0));
    ev_ready = 1'b1; cycle();
    check("ovf_drain", 32'(ev_pending), 32'(0));

    // en gating
    en = 1'b0; level = 4'b0100; repeat (3) cycle();
    check("en_pend", 32'(ev_pending), 32'(0));
    check("en_ovf", 32'(overflow), 32'(0));
    en = 1'b1; repeat (3) cycle();
    check("en_held", 32'(ev_valid), 32'(0));
    level = '0; repeat (2) cycle();
    level = 4'b0100; repeat (3) cycle();
    check("en_fresh_valid", 32'(ev_valid), 32'(1));
    check("en_fresh_ch", 32'(ev_ch), 32'(2));
    cycle(); level = '0; repeat (2) cycle();

    // reset mid-offer, ch1 held across release
    ev_ready = 1'b0; level = 4'b0010; repeat (3) cycle();
    check("mid_offer", 32'(ev_valid), 32'(1));
    reset = 1'b1; cycle();
    check("mid_rst_valid", 32'(ev_valid), 32'(0));
    check("mid_rst_pend", 32'(ev_pending), 32'(0));
    reset = 1'b0; repeat (3) cycle();
    check("rel_valid", 32'(ev_valid), 32'(1));
    check("rel_ch", 32'(ev_ch), 32'(1));
    ev_ready = 1'b1; cycle();
    check("rel_done", 32'(ev_valid), 32'(0));
    repeat (2) cycle();
    check("rel_once", 32'(ev_valid), 32'(0));
    level = '0; repeat (2) cycle();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) level[b] = ~level[b];
      end
      en           = ($urandom_range(0, 7) != 0);
      ev_ready     = ($urandom_range(0, 2) != 0);
      clr_overflow = ($urandom_range(0, 15) == 0);
      reset        = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
